// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared definitions for the RV32I instruction encoder.
//   - OPC_* : 7-bit major opcodes for each supported instruction class
//   - instr_cls_e : instruction class, bit index order matches the one-hot
//                   select vector {lui, jal, jalr, branch, store, load, i, r}
//   - encode() : pure function assembling a 32-bit instruction word
package instr_enc_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam int NUM_CLS = 8;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_LUI    = 3'd7
    } instr_cls_e;

    // Immediate bits outside each format's field are simply dropped.
    function automatic logic [31:0] encode(
        input instr_cls_e  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (cls)
            CLS_R:      w = {funct7, rs2, rs1, funct3, rd, OPC_R};
            CLS_I:      w = {imm[11:0], rs1, funct3, rd, OPC_I};
            CLS_LOAD:   w = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            CLS_STORE:  w = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], OPC_BRANCH};
            CLS_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            CLS_LUI:    w = {imm[31:12], rd, OPC_LUI};
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and output-word handshake bundle.
//   Request side : req_valid_i/req_ready_o, one-hot class select, operand fields
//   Output side  : instr_valid_o/instr_ready_i, instr_o, illegal_o pulse
//   modport slave  : the encoder
//   modport master : the requester / consumer
interface instr_encoder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        r_type_i;
    logic        i_type_i;
    logic        load_i;
    logic        store_i;
    logic        branch_i;
    logic        jalr_i;
    logic        jal_i;
    logic        lui_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        illegal_o;

    modport slave (
        input  req_valid_i, r_type_i, i_type_i, load_i, store_i, branch_i,
               jalr_i, jal_i, lui_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i,
               imm_i, instr_ready_i,
        output req_ready_o, instr_valid_o, instr_o, illegal_o
    );

    modport master (
        output req_valid_i, r_type_i, i_type_i, load_i, store_i, branch_i,
               jalr_i, jal_i, lui_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i,
               imm_i, instr_ready_i,
        input  req_ready_o, instr_valid_o, instr_o, illegal_o
    );
endinterface

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: circular-buffer FIFO holding encoded words.
//   clk_i, rst_ni : clock, async active-low reset (flushes pointers/count)
//   push, din     : write request / data (ignored when full)
//   ready         : !full, from the registered count only
//   pop           : head consumed (ignored when empty)
//   valid, dout   : head valid / head data (zero when empty)
module instr_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             full, empty, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= din;
    end

    assign ready = ~full;
    assign valid = ~empty;
    assign dout  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I words from a one-hot class select and
// operand fields, queuing them in a small FIFO toward the fetch side.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : request handshake + operands, output word handshake,
//                   illegal_o one-cycle pulse after a rejected request
// Optional macro INSTR_ENC_STATS_EN adds:
//   enc_count_o     [31:0] legal words pushed (wraps)
//   illegal_count_o [15:0] illegal requests (saturates)
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    instr_encoder_if.slave         bus
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [31:0]            enc_count_o,
    output logic [15:0]            illegal_count_o
`endif
);
    logic [NUM_CLS-1:0] sel;
    logic               one_hot, misaligned, illegal;
    logic               req_fire, push;
    logic               fifo_ready;
    logic               illegal_q;
    instr_cls_e         cls;
    logic [31:0]        word;

    assign sel = {bus.lui_i, bus.jal_i, bus.jalr_i, bus.branch_i,
                  bus.store_i, bus.load_i, bus.i_type_i, bus.r_type_i};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign one_hot    = (sel != '0) && ((sel & (sel - NUM_CLS'(1))) == '0);
    assign misaligned = (bus.branch_i | bus.jal_i) & bus.imm_i[0];
    assign illegal    = ~one_hot | misaligned;

    always_comb begin
        cls = CLS_R;
        for (int k = 0; k < NUM_CLS; k++) begin
            if (sel[k]) cls = instr_cls_e'(k[2:0]);
        end
    end

    assign word = encode(cls, bus.rd_i, bus.rs1_i, bus.rs2_i,
                         bus.funct3_i, bus.funct7_i, bus.imm_i);

    assign req_fire = bus.req_valid_i & fifo_ready;
    assign push     = req_fire & ~illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) illegal_q <= 1'b0;
        else         illegal_q <= req_fire & illegal;
    end

    instr_enc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .din    (word),
        .ready  (fifo_ready),
        .pop    (bus.instr_ready_i),
        .valid  (bus.instr_valid_o),
        .dout   (bus.instr_o)
    );

    assign bus.req_ready_o = fifo_ready;
    assign bus.illegal_o   = illegal_q;

`ifdef INSTR_ENC_STATS_EN
    logic [31:0] enc_cnt_q;
    logic [15:0] ill_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enc_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            if (push) enc_cnt_q <= enc_cnt_q + 32'd1;
            if (req_fire && illegal && ill_cnt_q != 16'hFFFF)
                ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign enc_count_o     = enc_cnt_q;
    assign illegal_count_o = ill_cnt_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: self-checking bench for instr_encoder (DEPTH=2).
// Directed vectors, illegal cases, backpressure, randomized traffic against a
// queue-based reference model, and asynchronous mid-operation reset.
module tb_instr_encoder;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

`ifdef INSTR_ENC_STATS_EN
    logic [31:0] enc_cnt;
    logic [15:0] ill_cnt;
`endif

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef INSTR_ENC_STATS_EN
        ,
        .enc_count_o     (enc_cnt),
        .illegal_count_o (ill_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;
    int exp_enc = 0;
    int exp_ill = 0;

    // current request: one-hot bit order r,i,load,store,branch,jalr,jal,lui
    logic [7:0]  c_oh;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [2:0]  c_f3;
    logic [6:0]  c_f7;
    logic [31:0] c_imm;

    // Reference encoder written as field placement by shift/mask arithmetic.
    function automatic logic [31:0] model_enc(input logic [7:0] oh, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] r, f, d, s1, s2, i7;
        r  = '0;
        d  = 32'(rd)  << 7;
        f  = 32'(f3)  << 12;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        i7 = (imm & 32'hFFF) << 20;
        if (oh == 8'h01) r = 32'h33 | d | f | s1 | s2 | (32'(f7) << 25);
        if (oh == 8'h02) r = 32'h13 | d | f | s1 | i7;
        if (oh == 8'h04) r = 32'h03 | d | f | s1 | i7;
        if (oh == 8'h08) r = 32'h23 | ((imm & 32'h1F) << 7) | f | s1 | s2
                             | (((imm >> 5) & 32'h7F) << 25);
        if (oh == 8'h10) r = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                             | f | s1 | s2 | (((imm >> 5) & 32'h3F) << 25)
                             | (((imm >> 12) & 32'h1) << 31);
        if (oh == 8'h20) r = 32'h67 | d | s1 | i7;
        if (oh == 8'h40) r = 32'h6F | d | (((imm >> 12) & 32'hFF) << 12)
                             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                             | (((imm >> 20) & 32'h1) << 31);
        if (oh == 8'h80) r = 32'h37 | d | (imm & 32'hFFFFF000);
        return r;
    endfunction

    function automatic bit model_illegal(input logic [7:0] oh, input logic [31:0] imm);
        return ($countones(oh) != 1) || ((oh == 8'h10 || oh == 8'h40) && imm[0]);
    endfunction

    task automatic drive_req(input logic valid);
        bus.req_valid_i = valid;
        {bus.lui_i, bus.jal_i, bus.jalr_i, bus.branch_i,
         bus.store_i, bus.load_i, bus.i_type_i, bus.r_type_i} = c_oh;
        bus.rd_i = c_rd; bus.rs1_i = c_rs1; bus.rs2_i = c_rs2;
        bus.funct3_i = c_f3; bus.funct7_i = c_f7; bus.imm_i = c_imm;
    endtask

    task automatic gen_req(input bit legal_only);
        int kind, a, b;
        kind = legal_only ? $urandom_range(0, 7) : $urandom_range(0, 9);
        if (kind < 8) c_oh = 8'(1 << kind);
        else if (kind == 8) c_oh = 8'h00;
        else begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            c_oh = 8'((1 << a) | (1 << b));
        end
        c_rd = 5'($urandom); c_rs1 = 5'($urandom); c_rs2 = 5'($urandom);
        c_f3 = 3'($urandom); c_f7 = 7'($urandom); c_imm = $urandom;
        if (legal_only) c_imm[0] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c_oh = '0; c_rd = '0; c_rs1 = '0; c_rs2 = '0; c_f3 = '0; c_f7 = '0; c_imm = '0;
        drive_req(1'b0);
        bus.instr_ready_i = 1'b0;
        #12;
        checks++; if (bus.req_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready_o); else passed++;
        checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.instr_valid_o); else passed++;
        checks++; if (bus.instr_o !== 32'h0) $display("FAIL reset_instr got %h want 0", bus.instr_o); else passed++;
        checks++; if (bus.illegal_o !== 1'b0) $display("FAIL reset_illegal got %b want 0", bus.illegal_o); else passed++;
`ifdef INSTR_ENC_STATS_EN
        checks++; if (enc_cnt !== 32'd0 || ill_cnt !== 16'd0) $display("FAIL reset_stats got %0d/%0d want 0/0", enc_cnt, ill_cnt); else passed++;
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  oh  [5] = '{8'h01, 8'h02, 8'h80, 8'h10, 8'h40};
        logic [4:0]  rd  [5] = '{5'd3, 5'd5, 5'd1, 5'd0, 5'd1};
        logic [4:0]  rs1 [5] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd0};
        logic [4:0]  rs2 [5] = '{5'd2, 5'd0, 5'd0, 5'd2, 5'd0};
        logic [31:0] imm [5] = '{32'h0, 32'hFFFFFFFF, 32'h12345000, 32'h8, 32'h800};
        logic [31:0] exp [5] = '{32'h002081B3, 32'hFFF00293, 32'h123450B7, 32'h00208463, 32'h001000EF};
        for (int i = 0; i < 5; i++) begin
            bus.instr_ready_i = 1'b0;
            c_oh = oh[i]; c_rd = rd[i]; c_rs1 = rs1[i]; c_rs2 = rs2[i];
            c_f3 = 3'd0; c_f7 = 7'd0; c_imm = imm[i];
            drive_req(1'b1);
            @(posedge clk); #1;
            bus.req_valid_i = 1'b0;
            exp_enc++;
            checks++; if (bus.instr_valid_o !== 1'b1) $display("FAIL dir%0d_valid got %b want 1", i, bus.instr_valid_o); else passed++;
            checks++; if (bus.instr_o !== exp[i]) $display("FAIL dir%0d_word got %h want %h", i, bus.instr_o, exp[i]); else passed++;
            checks++; if (bus.illegal_o !== 1'b0) $display("FAIL dir%0d_illegal got %b want 0", i, bus.illegal_o); else passed++;
            bus.instr_ready_i = 1'b1;
            @(posedge clk); #1;
            bus.instr_ready_i = 1'b0;
            checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL dir%0d_drain got %b want 0", i, bus.instr_valid_o); else passed++;
        end
    endtask

    task automatic test_illegal();
        logic [7:0]  oh  [4] = '{8'h03, 8'h10, 8'h00, 8'h40};
        logic [31:0] imm [4] = '{32'h0, 32'h7, 32'h4, 32'h801};
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_oh = oh[i]; c_rd = 5'd1; c_rs1 = 5'd1; c_rs2 = 5'd2;
            c_f3 = 3'd0; c_f7 = 7'd0; c_imm = imm[i];
            drive_req(1'b1);
            @(posedge clk); #1;
            bus.req_valid_i = 1'b0;
            exp_ill++;
            checks++; if (bus.illegal_o !== 1'b1) $display("FAIL ill%0d_pulse got %b want 1", i, bus.illegal_o); else passed++;
            checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL ill%0d_nopush got %b want 0", i, bus.instr_valid_o); else passed++;
`ifdef INSTR_ENC_STATS_EN
            if (i == 1) begin
                checks++; if (ill_cnt !== 16'd2) $display("FAIL ill_count2 got %0d want 2", ill_cnt); else passed++;
            end
`endif
            @(posedge clk); #1;
            checks++; if (bus.illegal_o !== 1'b0) $display("FAIL ill%0d_onepulse got %b want 0", i, bus.illegal_o); else passed++;
        end
`ifdef INSTR_ENC_STATS_EN
        checks++; if (ill_cnt !== 16'(exp_ill) || enc_cnt !== 32'(exp_enc))
            $display("FAIL ill_stats got %0d/%0d want %0d/%0d", ill_cnt, enc_cnt, exp_ill, exp_enc); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gen_req(1'b1);
            w[i] = model_enc(c_oh, c_rd, c_rs1, c_rs2, c_f3, c_f7, c_imm);
            drive_req(1'b1);
            if (i < 2) begin
                @(posedge clk); #1;
                checks++; if (bus.req_ready_o !== (i == 0)) $display("FAIL bp_ready%0d got %b want %b", i, bus.req_ready_o, i == 0); else passed++;
            end
        end
        // third request held while full
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", bus.req_ready_o); else passed++;
        checks++; if (bus.instr_o !== w[0]) $display("FAIL bp_stable got %h want %h", bus.instr_o, w[0]); else passed++;
        bus.instr_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.instr_o !== w[1]) $display("FAIL bp_order1 got %h want %h", bus.instr_o, w[1]); else passed++;
        checks++; if (bus.req_ready_o !== 1'b1) $display("FAIL bp_reopen got %b want 1", bus.req_ready_o); else passed++;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        checks++; if (bus.instr_o !== w[2]) $display("FAIL bp_order2 got %h want %h", bus.instr_o, w[2]); else passed++;
        @(posedge clk); #1;
        bus.instr_ready_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.instr_valid_o); else passed++;
        exp_enc += 3;
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        bit          exp_illegal = 1'b0;
        bit          acc, pop;
        int          errs = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready_o !== (q.size() < DEPTH) || bus.instr_valid_o !== (q.size() > 0)
                || bus.instr_o !== (q.size() > 0 ? q[0] : 32'h0) || bus.illegal_o !== exp_illegal) begin
                if (errs < 10)
                    $display("FAIL rnd_cycle%0d got rdy=%b vld=%b word=%h ill=%b want rdy=%b vld=%b word=%h ill=%b",
                             n, bus.req_ready_o, bus.instr_valid_o, bus.instr_o, bus.illegal_o,
                             q.size() < DEPTH, q.size() > 0, (q.size() > 0 ? q[0] : 32'h0), exp_illegal);
                errs++;
            end else passed++;
            gen_req(1'b0);
            drive_req($urandom_range(0, 3) != 0);
            bus.instr_ready_i = ($urandom_range(0, 2) != 0);
            acc = bus.req_valid_i && (q.size() < DEPTH);
            pop = bus.instr_ready_i && (q.size() > 0);
            if (pop) void'(q.pop_front());
            exp_illegal = acc && model_illegal(c_oh, c_imm);
            if (acc && !exp_illegal) begin
                q.push_back(model_enc(c_oh, c_rd, c_rs1, c_rs2, c_f3, c_f7, c_imm));
                exp_enc++;
            end
            if (exp_illegal) exp_ill++;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL rnd_drain got %b want 0", bus.instr_valid_o); else passed++;
`ifdef INSTR_ENC_STATS_EN
        checks++; if (enc_cnt !== 32'(exp_enc) || ill_cnt !== 16'(exp_ill))
            $display("FAIL rnd_stats got %0d/%0d want %0d/%0d", enc_cnt, ill_cnt, exp_enc, exp_ill); else passed++;
`endif
    endtask

    task automatic test_async_reset();
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            gen_req(1'b1);
            drive_req(1'b1);
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0)
            $display("FAIL ar_prefill got vld=%b rdy=%b want 1/0", bus.instr_valid_o, bus.req_ready_o); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid_o !== 1'b0) $display("FAIL ar_valid got %b want 0", bus.instr_valid_o); else passed++;
        checks++; if (bus.req_ready_o !== 1'b1) $display("FAIL ar_ready got %b want 1", bus.req_ready_o); else passed++;
        checks++; if (bus.instr_o !== 32'h0) $display("FAIL ar_word got %h want 0", bus.instr_o); else passed++;
`ifdef INSTR_ENC_STATS_EN
        checks++; if (enc_cnt !== 32'd0 || ill_cnt !== 16'd0) $display("FAIL ar_stats got %0d/%0d want 0/0", enc_cnt, ill_cnt); else passed++;
`endif
        @(negedge clk); rst_n = 1'b1;
        bus.instr_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1)
            $display("FAIL ar_after got vld=%b rdy=%b want 0/1", bus.instr_valid_o, bus.req_ready_o); else passed++;
        bus.instr_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles RV32I instruction words from a one-hot instruction-class selector and operand fields. This is the inverse of the core's opcode-class decoder. It sits on the test-generation and boot-ROM path and feeds encoded words through a small output FIFO to the fetch side, with valid/ready handshakes on both ports. Malformed requests are rejected and flagged instead of being encoded.

## Interface
- DEPTH, 2, output FIFO entries (≥2, power of two)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- r_type_i, i_type_i, load_i, store_i, branch_i, jalr_i, jal_i, lui_i  in  1 each  one-hot class select
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R only)
- imm_i  in  32  immediate, byte offset / full value
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  downstream accepts head
- instr_o  out  32  encoded word at FIFO head
- illegal_o  out  1  one-cycle pulse: last accepted request rejected

## Operation
- Handshake: a request transfers on req_valid_i & req_ready_o. An output word transfers on instr_valid_o & instr_ready_i.
- req_ready_o = !full, driven from a registered count. It does not depend on instr_ready_i in the same cycle.
- Opcodes:
  - R 0110011: funct7|rs2|rs1|funct3|rd
  - I 0010011: imm[11:0]|rs1|funct3|rd
  - LOAD 0000011: same layout as I
  - JALR 1100111: same layout as I, funct3 forced 000
  - STORE 0100011: imm[11:5]|rs2|rs1|funct3|imm[4:0]
  - BRANCH 1100011: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]
  - JAL 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd
  - LUI 0110111: imm[31:12]|rd
- Unused immediate bits are ignored. No range checking.
- A request is illegal if any of the following holds:
  - the class select is zero-hot or multi-hot;
  - it is BRANCH or JAL with imm_i[0]=1.
- An illegal request is still consumed (ready honoured). Nothing is pushed, and illegal_o pulses in the cycle after acceptance.
- FIFO: circular buffer with read/write pointers and a count of width $clog2(DEPTH)+1.
  - Push and pop in the same cycle when non-empty: count unchanged, order preserved.
  - When full, no push is possible. A pop that cycle raises req_ready_o on the next cycle.
  - When empty, instr_valid_o=0 and instr_o=0.

## Timing
- Reset values: req_ready_o=1, instr_valid_o=0, instr_o=0, illegal_o=0, count=0, pointers=0.
- Latency: a legal request accepted at edge N gives instr_valid_o=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput is one word per cycle while instr_ready_i=1.
- instr_o and instr_valid_o are stable while instr_valid_o & !instr_ready_i.
- Reset asserted mid-operation flushes the FIFO immediately (asynchronous). Words held at that point are discarded.
- illegal_o never overlaps with a push generated by the same request.

## Configuration
- INSTR_ENC_STATS_EN defined: adds two ports, both reset to 0.
  - enc_count_o, out, 32 bits: legal words pushed, wraps modulo 2^32.
  - illegal_count_o, out, 16 bits: illegal requests, saturates at 16'hFFFF.
- INSTR_ENC_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package instr_enc_pkg contains:
  - the opcode localparams (OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LUI);
  - a class enum;
  - a pure encode function returning the 32-bit word.
- Sub-module instr_enc_fifo (parameter DEPTH, WIDTH=32) holds the buffer, pointers and count. Top level does the illegal check, encoding and stats.

## Test plan
- R: rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> instr_o=0x002081B3 one cycle after acceptance.
- I: rd=5, rs1=0, funct3=0, imm=-1 -> 0xFFF00293. LUI: rd=1, imm=0x12345000 -> 0x123450B7.
- BRANCH: rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. JAL: rd=1, imm=0x800 -> 0x001000EF.
- Illegal cases:
  - r_type_i=i_type_i=1 -> illegal_o one pulse, no push;
  - BRANCH with imm=7 -> illegal_o;
  - illegal_count_o=2 when INSTR_ENC_STATS_EN is defined.
- Backpressure, DEPTH=2: hold instr_ready_i=0 and send 3 legal requests.
  - req_ready_o falls after the 2nd acceptance.
  - Releasing instr_ready_i drains the words in order, then the 3rd is accepted.
- Drive rst_ni low while 2 words are queued -> instr_valid_o=0 asynchronously and req_ready_o=1. After release, the FIFO is empty.
